// File: rtl/mem_writer_if.sv
// -----------------------------------------------------------------------------
// mem_writer_if
// Byte-stream input and memory write port of the instruction-memory loader.
//   in_data   [7:0]  byte from the source
//   in_valid         in_data is valid
//   in_ready         loader accepts a byte this cycle
//   wr_en            one-cycle memory write strobe
//   wr_addr  [31:0]  byte address of the write (multiple of 4)
//   wr_data  [31:0]  word to write
// master: the byte source / memory side. slave: the loader.
// -----------------------------------------------------------------------------
interface mem_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/mem_writer.sv
// -----------------------------------------------------------------------------
// mem_writer
// Assembles a byte stream into 32-bit little-endian words and writes them to
// consecutive word addresses of the instruction memory, starting at 0. The
// load ends on abort or when the next address would reach MEM_SIZE.
//
// Ports
//   sys_clk            clock
//   sys_rst            synchronous active-high reset
//   start              one-cycle pulse, begins a load at address 0
//   abort              ends the current load, flushing any partial word
//   bus (slave)        byte stream in, memory write port out
//   busy               high while collecting or writing
//   done               load finished, held until the next start
//   word_count [7:0]   words written in the current load
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   COLLECT | accepting bytes into word_buf
//   WRITE   | one-cycle memory write of word_buf
//   DONE    | load finished, waiting for start
// -----------------------------------------------------------------------------
module mem_writer #(
    parameter int unsigned MEM_SIZE = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    mem_writer_if.slave       bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        word_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] word_buf_q;
    logic        last_q;

    logic        in_ready_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  word_count_q;

    logic        xfer;
    logic [31:0] word_buf_d;
    logic [1:0]  byte_idx_d;
    logic        word_full;
    logic        buf_has_byte;
    logic [31:0] addr_d;
    logic        load_full;

    // in_ready_q is high exactly while in COLLECT, so the state alone
    // qualifies a transfer.
    always_comb begin
        xfer         = (state_q == S_COLLECT) && bus.in_valid;
        word_buf_d   = word_buf_q;
        byte_idx_d   = byte_idx_q;
        if (xfer) begin
            word_buf_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
            byte_idx_d = byte_idx_q + 2'd1;
        end
        word_full    = xfer && (byte_idx_q == 2'd3);
        // Counts the byte stored this cycle, so abort alongside a byte
        // still flushes it.
        buf_has_byte = xfer || (byte_idx_q != 2'd0);
        addr_d       = addr_q + 32'd4;
        load_full    = (addr_d >= 32'(MEM_SIZE));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            word_buf_q   <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_COLLECT;
                        addr_q       <= '0;
                        byte_idx_q   <= '0;
                        word_buf_q   <= '0;
                        last_q       <= 1'b0;
                        word_count_q <= '0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        in_ready_q   <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    word_buf_q <= word_buf_d;
                    byte_idx_q <= byte_idx_d;
                    if (word_full || (abort && buf_has_byte)) begin
                        // Write outputs are registered, so they are loaded on
                        // entry and are visible during the WRITE cycle itself.
                        state_q      <= S_WRITE;
                        last_q       <= abort;
                        in_ready_q   <= 1'b0;
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= addr_q;
                        wr_data_q    <= word_buf_d;
                        word_count_q <= word_count_q + 8'd1;
                    end else if (abort) begin
                        state_q    <= S_DONE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end

                S_WRITE: begin
                    wr_en_q    <= 1'b0;
                    addr_q     <= addr_d;
                    word_buf_q <= '0;
                    byte_idx_q <= '0;
                    if (last_q || load_full) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_COLLECT;
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_count   = word_count_q;

endmodule
